// File: rtl/nvram_port_arbiter.sv
// nvram_port_arbiter
// Shares the single-port work/hiscore RAM between the game CPU and the HPS
// ioctl side (hiscore / NVRAM save and restore). The CPU always wins the
// port; one HPS request at a time is buffered and slotted into the first
// cycle the CPU leaves the RAM idle. If the CPU keeps the port busy for
// too long, cpu_pause asks the core to hold its clock enable.
//
// Ports:
//   clk_sys, reset        system clock, asynchronous active-high reset
//   cpu_req/we/addr/din   CPU RAM access (priority master)
//   cpu_pause             clock-enable hold request back to the CPU
//   hps_rd/hps_we         one-cycle HPS strobes, sample hps_addr/hps_din
//   hps_dout              HPS read data, held until the next read
//   hps_busy              request outstanding, new strobes are ignored
//   hps_ack               one-cycle completion pulse
//   ram_addr/din/we       muxed RAM port
//   ram_dout              RAM read data, one cycle after the address

module nvram_port_arbiter #(
   parameter int unsigned AW       = 11,
   parameter int unsigned DW       = 8,
   parameter int unsigned MAX_WAIT = 64
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_din,
   output logic          cpu_pause,
   input  logic          hps_rd,
   input  logic          hps_we,
   input  logic [AW-1:0] hps_addr,
   input  logic [DW-1:0] hps_din,
   output logic [DW-1:0] hps_dout,
   output logic          hps_busy,
   output logic          hps_ack,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   output logic          ram_we,
   input  logic [DW-1:0] ram_dout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      READ = 2'd2,
      ACK  = 2'd3
   } state_t;

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   state_t        state;
   state_t        state_nxt;
   logic          buf_we;
   logic [AW-1:0] buf_addr;
   logic [DW-1:0] buf_data;
   logic [7:0]    wait_cnt;
   logic [7:0]    wait_cnt_nxt;
   logic          grant;
   logic          load_buf;
   logic          pause_nxt;

   // Next-state decode. A grant is any PEND cycle in which the CPU leaves
   // the port idle; the HPS then owns the RAM for exactly that cycle. The
   // starvation counter only runs while the CPU is blocking us and drops
   // back to zero whenever we are not waiting.
   always_comb begin
      state_nxt    = state;
      grant        = 1'b0;
      load_buf     = 1'b0;
      wait_cnt_nxt = 8'd0;
      case (state)
         IDLE: begin
            if (hps_we || hps_rd) begin
               load_buf  = 1'b1;
               state_nxt = PEND;
            end
         end
         PEND: begin
            if (cpu_req) begin
               wait_cnt_nxt = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
            end else begin
               grant     = 1'b1;
               state_nxt = buf_we ? ACK : READ;
            end
         end
         READ:    state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      pause_nxt = (state == PEND) && cpu_req && (wait_cnt >= MAX_WAIT_C);
   end

   // RAM port mux. Outside a grant cycle the CPU drives the port directly,
   // so only one master can ever assert ram_we.
   always_comb begin
      ram_addr = cpu_addr;
      ram_din  = cpu_din;
      ram_we   = cpu_req & cpu_we;
      if (grant) begin
         ram_addr = buf_addr;
         ram_din  = buf_data;
         ram_we   = buf_we;
      end
   end

   // State, flags and the single request buffer. busy and ack are looked
   // up from the next state so both come straight out of flops. The buffer
   // only loads in IDLE, which is what makes strobes during busy harmless;
   // hps_we wins over hps_rd when both arrive together. Read data is taken
   // at the end of READ, one cycle after the grant address was presented.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         wait_cnt  <= 8'd0;
         hps_busy  <= 1'b0;
         hps_ack   <= 1'b0;
         cpu_pause <= 1'b0;
         hps_dout  <= '0;
         buf_we    <= 1'b0;
         buf_addr  <= '0;
         buf_data  <= '0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_cnt_nxt;
         hps_busy  <= (state_nxt != IDLE);
         hps_ack   <= (state_nxt == ACK);
         cpu_pause <= pause_nxt;
         if (load_buf) begin
            buf_we   <= hps_we;
            buf_addr <= hps_addr;
            buf_data <= hps_din;
         end
         if (state == READ) begin
            hps_dout <= ram_dout;
         end
      end
   end

endmodule

// File: tb/tb_nvram_port_arbiter.sv
// tb_nvram_port_arbiter
// Directed bench for nvram_port_arbiter with a behavioural RAM and a
// transaction-level reference model that is compared on every negedge.

module tb_nvram_port_arbiter;

   localparam int AW       = 11;
   localparam int DW       = 8;
   localparam int MAX_WAIT = 4;

   logic          clk_sys = 1'b0;
   logic          reset;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_din;
   logic          cpu_pause;
   logic          hps_rd;
   logic          hps_we;
   logic [AW-1:0] hps_addr;
   logic [DW-1:0] hps_din;
   logic [DW-1:0] hps_dout;
   logic          hps_busy;
   logic          hps_ack;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic          ram_we;
   logic [DW-1:0] ram_dout;

   int checks   = 0;
   int failures = 0;

   nvram_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_din   (cpu_din),
      .cpu_pause (cpu_pause),
      .hps_rd    (hps_rd),
      .hps_we    (hps_we),
      .hps_addr  (hps_addr),
      .hps_din   (hps_din),
      .hps_dout  (hps_dout),
      .hps_busy  (hps_busy),
      .hps_ack   (hps_ack),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_we    (ram_we),
      .ram_dout  (ram_dout)
   );

   always #5 clk_sys = ~clk_sys;

   // Behavioural single-port RAM with registered read data.
   logic [DW-1:0] mem [0:2047];
   always @(posedge clk_sys) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Reference model: one outstanding HPS transaction described by how
   // many cycles it has waited and how many cycles have passed since it
   // got the port. The golden memory follows every expected RAM write.
   logic [DW-1:0] golden [0:2047];
   bit            m_has_req;
   bit            m_write;
   bit            m_granted;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   int            m_pend_cycles;
   int            m_since_grant;
   logic [DW-1:0] m_saved;
   logic [DW-1:0] m_dout;
   bit            m_pause;
   bit            e_grant;
   bit            e_ack;
   logic          e_we;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_din;

   initial begin
      m_has_req = 0; m_write = 0; m_granted = 0; m_addr = '0; m_data = '0;
      m_pend_cycles = 0; m_since_grant = 0; m_saved = '0; m_dout = '0; m_pause = 0;
   end

   always @(negedge clk_sys) begin
      if (reset) begin
         m_has_req = 0;
         m_granted = 0;
         m_pend_cycles = 0;
         m_since_grant = 0;
         m_dout = '0;
         m_pause = 0;
      end
      e_grant = m_has_req && !m_granted && !cpu_req;
      e_ack   = m_has_req && m_granted && (m_since_grant == (m_write ? 1 : 2));
      if (e_grant) begin
         e_we = m_write; e_addr = m_addr; e_din = m_data;
      end else begin
         e_we = cpu_req & cpu_we; e_addr = cpu_addr; e_din = cpu_din;
      end
      checkOutput("ram_we", ram_we, e_we);
      checkOutput("ram_addr", ram_addr, e_addr);
      checkOutput("ram_din", ram_din, e_din);
      checkOutput("hps_busy", hps_busy, m_has_req);
      checkOutput("hps_ack", hps_ack, e_ack);
      checkOutput("cpu_pause", cpu_pause, m_pause);
      checkOutput("hps_dout", hps_dout, m_dout);

      if (e_we) golden[e_addr] = e_din;
      if (!reset) begin
         if (m_has_req) begin
            if (m_granted && !m_write && m_since_grant == 1) m_dout = m_saved;
            if (e_ack) begin
               m_has_req = 0;
            end else if (e_grant) begin
               m_granted = 1;
               m_since_grant = 1;
               m_saved = golden[m_addr];
            end else if (m_granted) begin
               m_since_grant++;
            end else begin
               m_pend_cycles++;
            end
         end else if (hps_we || hps_rd) begin
            m_has_req = 1;
            m_write = hps_we;
            m_addr = hps_addr;
            m_data = hps_din;
            m_granted = 0;
            m_pend_cycles = 0;
         end
      end
      m_pause = !reset && m_has_req && !m_granted && (m_pend_cycles > MAX_WAIT);
   end

   task automatic applyStimulus(input logic cr, input logic cw, input logic [AW-1:0] ca,
                                input logic [DW-1:0] cd, input logic hr, input logic hw,
                                input logic [AW-1:0] ha, input logic [DW-1:0] hd);
      @(posedge clk_sys);
      #1;
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_din = cd;
      hps_rd = hr; hps_we = hw; hps_addr = ha; hps_din = hd;
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
   endtask

   task automatic probe();
      @(negedge clk_sys);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
      hps_rd = 0; hps_we = 0; hps_addr = '0; hps_din = '0;
      repeat (3) @(posedge clk_sys);
      #1 reset = 1'b0;
      probe();
      checkOutput("rst_busy", hps_busy, 0);
      checkOutput("rst_ack", hps_ack, 0);
      checkOutput("rst_pause", cpu_pause, 0);
      checkOutput("rst_dout", hps_dout, 0);

      // Preload through the CPU port
      applyStimulus(1, 1, 11'h010, 8'h3C, 0, 0, '0, '0);
      applyStimulus(1, 1, 11'h0B0, 8'h42, 0, 0, '0, '0);
      applyStimulus(1, 1, 11'h0C0, 8'h13, 0, 0, '0, '0);
      idleCycles(2);

      // HPS write with CPU idle
      applyStimulus(0, 0, '0, '0, 0, 1, 11'h123, 8'hA5);
      probe();
      checkOutput("t1_busy_c0", hps_busy, 0);
      idleCycles(1);
      probe();
      checkOutput("t1_we_c1", ram_we, 1);
      checkOutput("t1_addr_c1", ram_addr, 11'h123);
      checkOutput("t1_din_c1", ram_din, 8'hA5);
      checkOutput("t1_busy_c1", hps_busy, 1);
      idleCycles(1);
      probe();
      checkOutput("t1_ack_c2", hps_ack, 1);
      checkOutput("t1_busy_c2", hps_busy, 1);
      idleCycles(1);
      probe();
      checkOutput("t1_busy_c3", hps_busy, 0);
      checkOutput("t1_ack_c3", hps_ack, 0);

      // HPS read, CPU access during the capture cycle
      applyStimulus(0, 0, '0, '0, 1, 0, 11'h010, '0);
      idleCycles(1);
      applyStimulus(1, 0, 11'h7FF, '0, 0, 0, '0, '0);
      probe();
      checkOutput("t2_ack_c2", hps_ack, 0);
      idleCycles(1);
      probe();
      checkOutput("t2_ack_c3", hps_ack, 1);
      checkOutput("t2_dout_c3", hps_dout, 8'h3C);
      idleCycles(1);

      // CPU busy for 10 cycles with a pending HPS write
      applyStimulus(1, 0, 11'h300, '0, 0, 1, 11'h200, 8'h5A);
      for (int i = 1; i <= 9; i++)
         applyStimulus(1, i[0], 11'(11'h300 + i), 8'(i), 0, 0, '0, '0);
      applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
      probe();
      checkOutput("t3_we_grant", ram_we, 1);
      checkOutput("t3_addr_grant", ram_addr, 11'h200);
      checkOutput("t3_din_grant", ram_din, 8'h5A);
      idleCycles(1);
      probe();
      checkOutput("t3_ack", hps_ack, 1);
      idleCycles(1);

      // Starvation and cpu_pause
      applyStimulus(0, 0, '0, '0, 0, 1, 11'h055, 8'h11);
      for (int c = 1; c <= 8; c++) begin
         applyStimulus(1, 0, 11'h400, '0, 0, 0, '0, '0);
         if (c == 5) begin
            probe();
            checkOutput("t4_pause_c5", cpu_pause, 0);
         end
         if (c == 6) begin
            probe();
            checkOutput("t4_pause_c6", cpu_pause, 1);
         end
      end
      applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
      probe();
      checkOutput("t4_we_grant", ram_we, 1);
      checkOutput("t4_addr_grant", ram_addr, 11'h055);
      checkOutput("t4_pause_grant", cpu_pause, 1);
      idleCycles(1);
      probe();
      checkOutput("t4_pause_after", cpu_pause, 0);
      checkOutput("t4_ack", hps_ack, 1);
      idleCycles(1);

      // Simultaneous strobes and strobes while busy
      applyStimulus(0, 0, '0, '0, 1, 1, 11'h0A0, 8'h77);
      applyStimulus(0, 0, '0, '0, 0, 1, 11'h0B0, 8'hEE);
      probe();
      checkOutput("t5_we_grant", ram_we, 1);
      checkOutput("t5_addr_grant", ram_addr, 11'h0A0);
      applyStimulus(0, 0, '0, '0, 1, 0, 11'h0B0, '0);
      probe();
      checkOutput("t5_ack", hps_ack, 1);
      idleCycles(1);
      probe();
      checkOutput("t5_busy_after", hps_busy, 0);
      checkOutput("t5_ack_after", hps_ack, 0);
      idleCycles(2);
      checkOutput("t5_mem_0b0", mem[11'h0B0], 8'h42);
      checkOutput("t5_mem_0a0", mem[11'h0A0], 8'h77);

      // Reset while pending and paused
      applyStimulus(1, 0, 11'h3FF, '0, 0, 1, 11'h0C0, 8'h99);
      for (int c = 1; c <= 7; c++) applyStimulus(1, 0, 11'h3FF, '0, 0, 0, '0, '0);
      probe();
      checkOutput("t6_pause_pre", cpu_pause, 1);
      checkOutput("t6_busy_pre", hps_busy, 1);
      applyStimulus(1, 0, 11'h3FF, '0, 0, 0, '0, '0);
      #2 reset = 1'b1;
      #1;
      checkOutput("t6_busy_rst", hps_busy, 0);
      checkOutput("t6_pause_rst", cpu_pause, 0);
      checkOutput("t6_ack_rst", hps_ack, 0);
      idleCycles(2);
      reset = 1'b0;
      idleCycles(3);
      checkOutput("t6_mem_0c0", mem[11'h0C0], 8'h13);
      applyStimulus(0, 0, '0, '0, 1, 0, 11'h0A0, '0);
      idleCycles(3);
      probe();
      checkOutput("t6_ack_new", hps_ack, 1);
      checkOutput("t6_dout_new", hps_dout, 8'h77);
      idleCycles(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nvram_port_arbiter.md
Name: nvram_port_arbiter

Overview:
- Shares the single-port work/hiscore RAM between the game CPU and the HPS side.
- The HPS side handles hiscore/NVRAM save and restore over ioctl.
- The CPU always has priority. HPS accesses are buffered (one entry) and slotted into idle CPU cycles.
- If the CPU starves the HPS for too long, the block requests a CPU pause.
- It sits between the core's RAM bus, the hps_io ioctl glue and the RAM macro, all on clk_sys.

Parameters:
- AW, 11, RAM address width.
- DW, 8, RAM data width.
- MAX_WAIT, 64, number of PEND cycles before cpu_pause is asserted (range 1..255).

Ports:
- clk_sys  in  1  system clock (40 MHz).
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU RAM access valid this cycle.
- cpu_we  in  1  CPU write (qualified by cpu_req).
- cpu_addr  in  AW  CPU address.
- cpu_din  in  DW  CPU write data.
- cpu_pause  out  1  clock-enable hold request to the CPU.
- hps_rd  in  1  one-cycle HPS read strobe.
- hps_we  in  1  one-cycle HPS write strobe.
- hps_addr  in  AW  HPS address, sampled with a strobe.
- hps_din  in  DW  HPS write data, sampled with a strobe.
- hps_dout  out  DW  HPS read data.
- hps_busy  out  1  request outstanding; new strobes are ignored.
- hps_ack  out  1  one-cycle completion pulse.
- ram_addr  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_dout  in  DW  RAM read data, registered (1-cycle latency).

Behaviour:
- Clock and reset: one clock (clk_sys). Reset is asynchronous and active-high.
- Reset values: state=IDLE, hps_busy=0, hps_ack=0, hps_dout=0, cpu_pause=0, wait_cnt=0, buffer cleared.
- Reset mid-operation: the pending HPS request is dropped and no ack is issued.
- Buffer: one entry holding {op, addr, data}. It is loaded only in IDLE.
- States:
  - IDLE: on hps_we or hps_rd, load the buffer and go to PEND. If both strobes arrive in the same cycle, the write wins and the read is dropped.
  - PEND: wait_cnt increments each cycle, saturating at 255.
    - If cpu_req=1, stay in PEND; the RAM port carries the CPU access.
    - If cpu_req=0, the HPS owns the RAM port this cycle (grant cycle). Go to ACK if op=write, READ if op=read. wait_cnt clears on exit.
  - READ: capture ram_dout into hps_dout at the end of this cycle (data from the grant-cycle address). The RAM port belongs to the CPU again. Go to ACK.
  - ACK: hps_ack=1 for exactly this cycle; hps_dout is valid for reads. Go to IDLE.
- RAM mux (combinational):
  - Grant cycle: ram_addr=buf_addr, ram_din=buf_data, ram_we=(op==write).
  - Otherwise: ram_addr=cpu_addr, ram_din=cpu_din, ram_we=cpu_req&cpu_we.
  - Exactly one master drives ram_we in any cycle.
- hps_busy: registered. It is 1 in every cycle where state≠IDLE, including the ACK cycle, and 0 in IDLE. Strobes arriving while busy=1 are ignored with no side effect.
- hps_dout: holds its value until the next read capture.
- Latency with CPU idle, strobe in cycle 0:
  - Write: PEND/grant in cycle 1, ack in cycle 2, busy=0 from cycle 3.
  - Read: grant in cycle 1, capture in cycle 2, ack with data in cycle 3.
  - Each cycle of cpu_req=1 while in PEND adds one cycle.
- Starvation:
  - cpu_pause is registered. It rises the cycle after wait_cnt reaches MAX_WAIT while still in PEND.
  - It falls the cycle after the state leaves PEND.
  - The core stops issuing cpu_req within bounded cycles of cpu_pause. The arbiter does not force a grant while cpu_req=1.
- Simultaneous events:
  - A strobe in the ACK cycle is ignored (busy=1).
  - cpu_req in the READ cycle is served normally; captured data is unaffected.

Test Plan:
- Idle CPU, hps_we addr=0x123 data=0xA5 at cycle 0 → ram_we=1, ram_addr=0x123, ram_din=0xA5 in cycle 1; hps_ack in cycle 2; busy 1 for cycles 1–2.
- Preload RAM[0x010]=0x3C, idle CPU, hps_rd 0x010 → hps_ack in cycle 3 with hps_dout=0x3C; cpu_req=1 with addr 0x7FF in cycle 2 does not corrupt hps_dout.
- cpu_req=1 continuously for 10 cycles, then 0, with a pending HPS write → CPU owns the port for all 10 cycles; grant in the first cpu_req=0 cycle; ack one cycle later; no cycle with two writers.
- MAX_WAIT=4, cpu_req stuck at 1 → cpu_pause=1 from cycle 6 (PEND entered in cycle 1); drop cpu_req → grant, then cpu_pause=0 the next cycle, then ack.
- hps_we and hps_rd in the same cycle, plus a second strobe while busy → exactly one write executes, one ack; the second strobe is ignored; RAM unchanged at the second address.
- Assert reset while in PEND → all outputs at reset values immediately; no ack; no RAM write afterward; a new request after reset completes normally.
